// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment bit indices, hex glyph table and glyph decoder shared by display encode/decode paths
package seven_seg_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Indexed by nibble value; each entry is {A,B,C,D,E,F,G}, 1 = lit.
   localparam logic [6:0] GLYPH_TABLE [0:15] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   // Returns {illegal, nibble}; unknown patterns decode to nibble 0 with illegal set.
   function automatic logic [4:0] glyph_to_nibble(input logic [6:0] glyph);
      logic [4:0] result;
      result = 5'b1_0000;
      for (int i = 0; i < 16; i++) begin
         if (glyph == GLYPH_TABLE[i]) begin
            result = {1'b0, 4'(i)};
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/seg_stable_detect.sv
// rtl/seg_stable_detect.sv - two-flop sync, polarity normalise and stability counter with one-shot arming
module seg_stable_detect #(
   parameter int             W             = 12,
   parameter int             STABLE_CYCLES = 16,
   parameter logic [W-1:0]   INV_MASK      = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   input  logic         capture,
   output logic [W-1:0] s,
   output logic         hit
);

   localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

   logic [W-1:0] sync1;
   logic [W-1:0] sync2;
   logic [W-1:0] s_prev;
   logic [15:0]  cnt;
   logic         armed;

   assign s   = sync2 ^ INV_MASK;
   assign hit = (s == s_prev) && (cnt == CNT_MAX) && armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         s_prev <= '0;
         cnt    <= '0;
         armed  <= 1'b0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         s_prev <= s;
         if (s != s_prev) begin
            cnt   <= '0;
            armed <= 1'b1;
         end else begin
            if (cnt < CNT_MAX) begin
               cnt <= cnt + 16'd1;
            end
            // Only a real capture disarms; blanking keeps the period armed but inert.
            if (capture) begin
               armed <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - recovers hex digits from a multiplexed seven-segment bus and publishes whole frames
module seven_segment_reader
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int STABLE_CYCLES  = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            seg,
   input  logic [N_DIGITS-1:0]   dig,
   output logic [4*N_DIGITS-1:0] value,
   output logic [N_DIGITS-1:0]   dp,
   output logic [N_DIGITS-1:0]   err,
   output logic                  frame_valid
);

   localparam int                 W        = N_DIGITS + 8;
   localparam logic [W-1:0]       INV_MASK = {{N_DIGITS{DIG_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};
   localparam logic [N_DIGITS-1:0] DIG_ONE = N_DIGITS'(1);

   logic [W-1:0]          s;
   logic                  hit;
   logic                  capture;
   logic                  one_hot;
   logic [N_DIGITS-1:0]   dig_n;
   logic [7:0]            seg_n;
   logic [4:0]            dec;
   logic                  frame_done;

   logic [4*N_DIGITS-1:0] shadow_val;
   logic [N_DIGITS-1:0]   shadow_dp;
   logic [N_DIGITS-1:0]   shadow_err;
   logic [N_DIGITS-1:0]   seen;
   logic [N_DIGITS-1:0]   seen_nxt;

   seg_stable_detect #(
      .W             (W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .INV_MASK      (INV_MASK)
   ) u_stable (
      .clk     (clk),
      .rst     (rst),
      .raw     ({dig, seg}),
      .capture (capture),
      .s       (s),
      .hit     (hit)
   );

   assign dig_n      = s[W-1:8];
   assign seg_n      = s[7:0];
   assign one_hot    = (dig_n != '0) && ((dig_n & (dig_n - DIG_ONE)) == '0);
   assign capture    = hit && one_hot;
   assign dec        = glyph_to_nibble({seg_n[SEG_A], seg_n[SEG_B], seg_n[SEG_C], seg_n[SEG_D],
                                        seg_n[SEG_E], seg_n[SEG_F], seg_n[SEG_G]});
   assign frame_done = &seen;

   // A capture landing on the completion cycle starts the next frame's mask.
   always_comb begin
      seen_nxt = frame_done ? '0 : seen;
      if (capture) begin
         seen_nxt = seen_nxt | dig_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_val  <= '0;
         shadow_dp   <= '0;
         shadow_err  <= '0;
         seen        <= '0;
         value       <= '0;
         dp          <= '0;
         err         <= '0;
         frame_valid <= 1'b0;
      end else begin
         seen        <= seen_nxt;
         frame_valid <= frame_done;
         if (frame_done) begin
            value <= shadow_val;
            dp    <= shadow_dp;
            err   <= shadow_err;
         end
         for (int i = 0; i < N_DIGITS; i++) begin
            if (capture && dig_n[i]) begin
               shadow_val[4*i +: 4] <= dec[3:0];
               shadow_dp[i]         <= seg_n[SEG_DP];
               shadow_err[i]        <= dec[4];
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - directed-vector bench for seven_segment_reader, active-high and active-low builds
module tb_seven_segment_reader;

   localparam logic [6:0] G0 = 7'b1111110;
   localparam logic [6:0] G1 = 7'b0110000;
   localparam logic [6:0] G2 = 7'b1101101;
   localparam logic [6:0] G3 = 7'b1111001;
   localparam logic [6:0] G4 = 7'b0110011;
   localparam logic [6:0] G5 = 7'b1011011;
   localparam logic [6:0] G6 = 7'b1011111;
   localparam logic [6:0] G7 = 7'b1110000;
   localparam logic [6:0] G8 = 7'b1111111;
   localparam logic [6:0] G9 = 7'b1111011;
   localparam logic [6:0] GA = 7'b1110111;
   localparam logic [6:0] GF = 7'b1000111;
   localparam logic [6:0] GX = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_al;
   logic [7:0]  seg;
   logic [3:0]  dig;
   logic [7:0]  seg_al;
   logic [3:0]  dig_al;
   logic [15:0] value,  value_al;
   logic [3:0]  dp,     dp_al;
   logic [3:0]  err,    err_al;
   logic        frame_valid, frame_valid_al;

   int n_vec  = 0;
   int n_miss = 0;
   int fv_cnt = 0;
   int fv_al_cnt = 0;
   int fv0;

   assign seg_al = ~seg;
   assign dig_al = ~dig;

   always #5 clk = ~clk;

   seven_segment_reader #(
      .N_DIGITS(4), .STABLE_CYCLES(16), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
   ) u_dut (
      .clk(clk), .rst(rst), .seg(seg), .dig(dig),
      .value(value), .dp(dp), .err(err), .frame_valid(frame_valid)
   );

   seven_segment_reader #(
      .N_DIGITS(4), .STABLE_CYCLES(16), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) u_dut_al (
      .clk(clk), .rst(rst_al), .seg(seg_al), .dig(dig_al),
      .value(value_al), .dp(dp_al), .err(err_al), .frame_valid(frame_valid_al)
   );

   always @(negedge clk) begin
      if (frame_valid === 1'b1)    fv_cnt++;
      if (frame_valid_al === 1'b1) fv_al_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic hold_raw(input logic [7:0] s, input logic [3:0] d, input int cyc);
      seg = s;
      dig = d;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic show(input int idx, input logic [6:0] g, input logic p, input int cyc);
      hold_raw({g, p}, 4'(1 << idx), cyc);
   endtask

   initial begin
      rst    = 1'b1;
      rst_al = 1'b1;
      seg    = 8'($urandom);
      dig    = 4'($urandom);
      repeat (3) begin
         @(negedge clk);
         seg = 8'($urandom);
         dig = 4'($urandom);
      end
      check("rst_value", 32'(value), 32'h0);
      check("rst_dp",    32'(dp),    32'h0);
      check("rst_err",   32'(err),   32'h0);
      check("rst_fv",    32'(frame_valid), 32'h0);
      check("rst_fv_cnt", 32'(fv_cnt), 32'h0);
      seg = 8'h00;
      dig = 4'h0;
      rst = 1'b0;
      repeat (4) @(negedge clk);

      fv0 = fv_cnt;
      show(0, G1, 1'b0, 40);
      show(1, G2, 1'b0, 40);
      show(2, G3, 1'b0, 40);
      show(3, GF, 1'b0, 40);
      hold_raw(8'h00, 4'h0, 10);
      check("clean_frames", 32'(fv_cnt - fv0), 32'd1);
      check("clean_value",  32'(value), 32'hF321);
      check("clean_err",    32'(err),   32'h0);
      check("clean_dp",     32'(dp),    32'h0);

      fv0 = fv_cnt;
      show(1, G1, 1'b0, 40);
      show(2, G2, 1'b0, 40);
      show(0, G8, 1'b0, 40);
      show(0, G0, 1'b0, 5);
      show(0, G8, 1'b0, 40);
      show(3, G3, 1'b0, 40);
      hold_raw(8'h00, 4'h0, 10);
      check("glitch_frames", 32'(fv_cnt - fv0), 32'd1);
      check("glitch_value",  32'(value), 32'h3218);

      fv0 = fv_cnt;
      show(1, G1, 1'b0, 40);
      show(0, G8, 1'b0, 10);
      show(0, G0, 1'b0, 5);
      show(2, G2, 1'b0, 40);
      show(3, G3, 1'b0, 40);
      hold_raw(8'h00, 4'h0, 10);
      check("short_glyph_no_frame", 32'(fv_cnt - fv0), 32'd0);
      show(0, G8, 1'b0, 40);
      hold_raw(8'h00, 4'h0, 10);
      check("late_digit_frame", 32'(fv_cnt - fv0), 32'd1);
      check("late_digit_value", 32'(value), 32'h3218);

      fv0 = fv_cnt;
      show(0, GA, 1'b0, 40);
      show(1, GA, 1'b0, 40);
      show(2, GX, 1'b1, 40);
      show(3, GA, 1'b0, 40);
      hold_raw(8'h00, 4'h0, 10);
      check("illegal_frames", 32'(fv_cnt - fv0), 32'd1);
      check("illegal_value",  32'(value), 32'hA0AA);
      check("illegal_err",    32'(err),   32'h4);
      check("illegal_dp",     32'(dp),    32'h4);

      fv0 = fv_cnt;
      show(0, G1, 1'b0, 40);
      hold_raw({G8, 1'b0}, 4'b0000, 40);
      show(1, G2, 1'b0, 40);
      hold_raw({G8, 1'b1}, 4'b0011, 40);
      show(2, G3, 1'b0, 40);
      hold_raw({G9, 1'b1}, 4'b0000, 40);
      show(3, GF, 1'b0, 40);
      hold_raw(8'h00, 4'h0, 10);
      check("blank_frames", 32'(fv_cnt - fv0), 32'd1);
      check("blank_value",  32'(value), 32'hF321);
      check("blank_err",    32'(err),   32'h0);
      check("blank_dp",     32'(dp),    32'h0);

      rst_al = 1'b0;
      hold_raw(8'h00, 4'h0, 5);
      fv0 = fv_al_cnt;
      show(0, G9, 1'b0, 40);
      show(1, G9, 1'b0, 40);
      rst_al = 1'b1;
      show(1, G9, 1'b0, 3);
      rst_al = 1'b0;
      show(2, G6, 1'b0, 40);
      show(3, G7, 1'b0, 40);
      show(0, G4, 1'b0, 40);
      show(1, G5, 1'b0, 40);
      hold_raw(8'h00, 4'h0, 10);
      check("al_frames", 32'(fv_al_cnt - fv0), 32'd1);
      check("al_value",  32'(value_al), 32'h7654);
      check("al_err",    32'(err_al),   32'h0);
      check("al_dp",     32'(dp_al),    32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receive-side counterpart of the seven-segment display path: samples an externally driven, multiplexed seven-segment bus (segment lines plus one-hot digit selects).
- Recovers the hex nibble shown on each digit.
- Publishes a coherent multi-digit value once every digit has been captured.
- Sits at the icoboard top level between the PMOD input pins and downstream logic such as a LED or compare block.

Parameters:
- N_DIGITS, 4, number of multiplexed digits / width of digit-select bus.
- STABLE_CYCLES, 16, consecutive identical samples needed before a capture (min 2, max 65535).
- SEG_ACTIVE_LOW, 0, 1 means segment pins are low when lit; inverted after sync.
- DIG_ACTIVE_LOW, 0, 1 means the digit select is low when active; inverted after sync.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- seg  input  8  raw segment pins, order {A,B,C,D,E,F,G,DP}, A = bit 7, DP = bit 0.
- dig  input  N_DIGITS  raw digit selects; bit i selects digit i (digit 0 = least significant nibble).
- value  output  4*N_DIGITS  last complete frame; digit i at bits [4i+3:4i].
- dp  output  N_DIGITS  decimal-point state per digit for the last frame.
- err  output  N_DIGITS  1 = digit's pattern in the last frame was not a legal hex glyph.
- frame_valid  output  1  one-cycle pulse when value/dp/err update.

Behaviour:
- Reset: value=0, dp=0, err=0, frame_valid=0. Internal state also clears: sync flops, stability counter, armed flag, seen mask, shadow registers.
- Reset is sampled on clk only; asserting rst mid-frame discards the partial frame; no frame_valid is emitted for it.
- Input sync: seg and dig each pass through 2 flops. Polarity is then normalised so internal 1 = lit/active.
- Stability:
  - s = {dig_n, seg_n} (normalised). s_prev is registered.
  - If s != s_prev: cnt=0, armed=1.
  - Else if cnt < STABLE_CYCLES-1: cnt++ (saturating).
- Capture condition: s == s_prev, cnt == STABLE_CYCLES-1, armed=1, and dig_n exactly one-hot. On capture, armed is cleared, so each stable period captures at most once.
- Non-captures: dig_n all-zero (blanking) or multi-hot never captures, and does not disturb the seen mask.
- Decode of seg_n[7:1] (A..G):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern gives nibble 0 with the shadow err bit set.
- On capture of digit i: shadow_val[i] <= nibble, shadow_dp[i] <= seg_n[0], shadow_err[i] <= illegal, seen[i] <= 1. Recapturing an already-seen digit overwrites its shadow entry.
- Frame completion:
  - The cycle after seen becomes all-ones, value/dp/err load from the shadow registers, frame_valid=1 for exactly one cycle, and seen clears.
  - If a capture coincides with the completion cycle, seen ends holding only the new digit's bit.
- Latency: a stable glyph applied at raw pins at cycle 0 is captured at cycle 2+STABLE_CYCLES. frame_valid follows 1 cycle after the final digit's capture.
- Outputs change only on frame_valid cycles; they are otherwise held.

Decomposition:
- Shared package seven_seg_pkg holds:
  - segment bit-index constants (SEG_A..SEG_DP);
  - the 16-entry glyph table;
  - decode function glyph_to_nibble returning {illegal, nibble[3:0]}.
- The encoder side uses the same table, so both directions stay consistent.
- One sub-module: seg_stable_detect (2-flop sync + compare + saturating counter + armed flag, width-parameterised). It outputs s and a capture-strobe precursor.

Test Plan:
- Reset: hold rst 3 cycles with random pins -> value=0, dp=0, err=0, frame_valid never 1.
- Clean frame: cycle digits 0..3 showing 1,2,3,F (patterns 0110000, 1101101, 1111001, 1000111), DP off, 40 cycles each, STABLE_CYCLES=16 -> single frame_valid pulse, value=16'hF321, err=0.
- Glitch rejection: hold digit 0 = "8", inject a 5-cycle change to "0" -> no capture of "0". Stability restarts and "8" is captured once, 16 cycles after the glitch ends.
- Illegal glyph plus DP: digit 2 shows 0000001 with DP lit, other digits show "A" -> value=16'hA0AA, err=4'b0100, dp=4'b0100.
- Blanking/multi-hot: insert dig=0000 and dig=0011 dwell periods of 40 cycles between digits -> no captures, frame result is identical to the clean-frame case.
- Active-low plus mid-frame reset: SEG_ACTIVE_LOW=DIG_ACTIVE_LOW=1, capture digits 0-1, pulse rst, then present a full frame of 4,5,6,7 -> exactly one frame_valid, value=16'h7654.
